// File: rtl/dec_lut_search_decoder.sv
// Inverse triangular-number decoder: returns the largest N with N*(N+1)/2 <= W.
// Top LUT_BITS of N resolve in one cycle against constant thresholds, the rest MSB-first one bit per cycle.
module dec_lut_search_decoder #(
  parameter int N_BITS   = 30,
  parameter int LUT_BITS = 4,
  parameter int W_BITS   = 2*N_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_BITS-1:0] W,
  output logic              found,
  input  logic              out_ready,
  output logic [N_BITS-1:0] N,
  output logic              exact,
  output logic              sat,
  output logic              busy
);

  localparam int S     = N_BITS - LUT_BITS;
  localparam int E_W   = 2*N_BITS + 1;
  localparam int CNT_W = (S > 1) ? $clog2(S) : 1;
  localparam logic [CNT_W-1:0] B_INIT = (S > 0) ? CNT_W'(S - 1) : '0;

  typedef enum logic [1:0] {IDLE, LUT, SEARCH, DONE} state_t;

  state_t            state;
  logic [W_BITS-1:0] w_q;
  logic [N_BITS-1:0] cand_q;
  logic [CNT_W-1:0]  b_q;
  logic              sat_q;

  logic [E_W-1:0]    w_ext;
  logic [N_BITS-1:0] lut_cand;
  logic [N_BITS-1:0] trial;
  logic [N_BITS-1:0] srch_cand;
  logic [N_BITS-1:0] done_cand;
  logic              exact_nxt;
  logic              sat_nxt;

  // Product is formed one bit wider than 2*N_BITS so n*(n+1) never wraps.
  function automatic logic [E_W-1:0] enc(input logic [N_BITS-1:0] n);
    logic [E_W-1:0] a;
    a = E_W'(n);
    return (a * (a + E_W'(1))) >> 1;
  endfunction

  function automatic logic is_sat(input logic [E_W-1:0] w);
    return w > enc('1);
  endfunction

  assign w_ext = E_W'(w_q);

  // Thresholds grow monotonically, so the last satisfied one is the largest k.
  always_comb begin
    lut_cand = '0;
    for (longint k = 1; k < (longint'(1) << LUT_BITS); k++) begin
      if (enc(N_BITS'(k) << S) <= w_ext) lut_cand = N_BITS'(k) << S;
    end
  end

  assign trial     = cand_q | (N_BITS'(1) << b_q);
  assign srch_cand = (enc(trial) <= w_ext) ? trial : cand_q;
  assign done_cand = (state == LUT) ? lut_cand : srch_cand;
  assign exact_nxt = (enc(done_cand) == w_ext);
  assign sat_nxt   = is_sat(w_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      w_q      <= '0;
      cand_q   <= '0;
      b_q      <= '0;
      sat_q    <= 1'b0;
      found    <= 1'b0;
      N        <= '0;
      exact    <= 1'b0;
      sat      <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w_q      <= W;
            state    <= LUT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        LUT: begin
          cand_q <= lut_cand;
          sat_q  <= sat_nxt;
          b_q    <= B_INIT;
          if (S > 0) begin
            state <= SEARCH;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            found <= 1'b1;
            N     <= lut_cand;
            exact <= exact_nxt;
            sat   <= sat_nxt;
          end
        end
        SEARCH: begin
          cand_q <= srch_cand;
          b_q    <= b_q - CNT_W'(1);
          if (b_q == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            found <= 1'b1;
            N     <= srch_cand;
            exact <= exact_nxt;
            sat   <= sat_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            state    <= IDLE;
            found    <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_lut_search_decoder.sv
// Bench for dec_lut_search_decoder: default instance plus two N_BITS=8 instances (LUT_BITS=8 and 1).
module tb_dec_lut_search_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n0, in_valid0, in_ready0, found0, out_ready0, exact0, sat0, busy0;
  logic [59:0] W0;
  logic [29:0] N0;

  logic        rst_ns, in_valid_s, out_ready_s;
  logic [15:0] W_s;
  logic        in_ready1, found1, exact1, sat1, busy1;
  logic        in_ready2, found2, exact2, sat2, busy2;
  logic [7:0]  N1, N2;

  dec_lut_search_decoder u_dut (
    .clk(clk), .rst_n(rst_n0), .in_valid(in_valid0), .in_ready(in_ready0), .W(W0),
    .found(found0), .out_ready(out_ready0), .N(N0), .exact(exact0), .sat(sat0), .busy(busy0));

  dec_lut_search_decoder #(.N_BITS(8), .LUT_BITS(8)) u_dut_l8 (
    .clk(clk), .rst_n(rst_ns), .in_valid(in_valid_s), .in_ready(in_ready1), .W(W_s),
    .found(found1), .out_ready(out_ready_s), .N(N1), .exact(exact1), .sat(sat1), .busy(busy1));

  dec_lut_search_decoder #(.N_BITS(8), .LUT_BITS(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_ns), .in_valid(in_valid_s), .in_ready(in_ready2), .W(W_s),
    .found(found2), .out_ready(out_ready_s), .N(N2), .exact(exact2), .sat(sat2), .busy(busy2));

  typedef struct {
    logic [63:0] n;
    logic        ex;
    logic        sat;
    int          lat;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int   n_checks = 0, n_err = 0;
  int   cyc = 0, acc0 = 0, acc0_prev = 0, acc1 = 0, acc2 = 0;
  logic found0_d = 1'b0, found1_d = 1'b0, found2_d = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compare_out(input string tag, input exp_t e, input logic [63:0] n,
                             input logic ex, input logic s, input int lat);
    check_eq({tag, "_n"}, n, e.n);
    check_eq({tag, "_exact"}, 64'(ex), 64'(e.ex));
    check_eq({tag, "_sat"}, 64'(s), 64'(e.sat));
    check_eq({tag, "_lat"}, 64'(lat), 64'(e.lat));
  endtask

  function automatic logic [63:0] enc_m(input logic [63:0] n);
    return (n * (n + 64'd1)) >> 1;
  endfunction

  // Reference: real-valued closed-form root, then nudged to the exact floor.
  function automatic exp_t model(input logic [63:0] w, input int nb, input int lat);
    exp_t        r;
    logic [63:0] mx, n;
    mx    = (64'd1 << nb) - 64'd1;
    r.lat = lat;
    if (w > enc_m(mx)) begin
      r.n = mx; r.ex = 1'b0; r.sat = 1'b1;
    end else begin
      n = 64'($rtoi(($sqrt(8.0 * real'(w) + 1.0) - 1.0) / 2.0));
      if (n > mx) n = mx;
      while (n > 0 && enc_m(n) > w) n--;
      while (n < mx && enc_m(n + 64'd1) <= w) n++;
      r.n = n; r.ex = (enc_m(n) == w); r.sat = 1'b0;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid0 && in_ready0) begin
      acc0_prev <= acc0;
      acc0      <= cyc + 1;
    end
    if (in_valid_s && in_ready1) acc1 <= cyc + 1;
    if (in_valid_s && in_ready2) acc2 <= cyc + 1;
  end

  always @(negedge clk) begin
    if (found0 && !found0_d) begin
      if (q0.size() == 0) check_eq("m0_sb_empty", 64'(q0.size()), 64'd1);
      else compare_out("m0", q0.pop_front(), 64'(N0), exact0, sat0, cyc - acc0);
    end
    if (found1 && !found1_d) begin
      if (q1.size() == 0) check_eq("m1_sb_empty", 64'(q1.size()), 64'd1);
      else compare_out("m1", q1.pop_front(), 64'(N1), exact1, sat1, cyc - acc1);
    end
    if (found2 && !found2_d) begin
      if (q2.size() == 0) check_eq("m2_sb_empty", 64'(q2.size()), 64'd1);
      else compare_out("m2", q2.pop_front(), 64'(N2), exact2, sat2, cyc - acc2);
    end
    found0_d <= found0;
    found1_d <= found1;
    found2_d <= found2;
  end

  task automatic wait_ready0(input string tag);
    int t = 0;
    while (!in_ready0 && t < 100) begin @(negedge clk); t++; end
    if (!in_ready0) check_eq({tag, "_ready_timeout"}, 64'(in_ready0), 64'd1);
  endtask

  task automatic send0(input logic [59:0] w);
    wait_ready0("send0");
    W0 = w; in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
  endtask

  task automatic wait_found0(input string tag);
    int t = 0;
    while (!found0 && t < 100) begin @(negedge clk); t++; end
    if (!found0) check_eq({tag, "_found_timeout"}, 64'(found0), 64'd1);
  endtask

  task automatic consume0(input string tag);
    out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0;
    check_eq({tag, "_found_clr"}, 64'(found0), 64'd0);
    check_eq({tag, "_in_ready"}, 64'(in_ready0), 64'd1);
  endtask

  task automatic send_s(input logic [15:0] w);
    int t = 0;
    while (!(in_ready1 && in_ready2) && t < 100) begin @(negedge clk); t++; end
    if (!(in_ready1 && in_ready2)) check_eq("sweep_ready_timeout", 64'(in_ready1 && in_ready2), 64'd1);
    W_s = w; in_valid_s = 1'b1;
    @(negedge clk);
    in_valid_s = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [59:0] wr;
    logic [15:0] ws;
    int          t;
    rst_n0 = 1'b0; rst_ns = 1'b0; in_valid0 = 1'b0; W0 = '0; out_ready0 = 1'b0;
    in_valid_s = 1'b0; W_s = '0; out_ready_s = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_found", 64'(found0), 64'd0);
    check_eq("rst_n", 64'(N0), 64'd0);
    check_eq("rst_exact", 64'(exact0), 64'd0);
    check_eq("rst_sat", 64'(sat0), 64'd0);
    check_eq("rst_busy", 64'(busy0), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready0), 64'd1);
    check_eq("rst_busy_sweep", 64'(busy1 | busy2), 64'd0);
    rst_n0 = 1'b1; rst_ns = 1'b1;
    @(negedge clk);

    q0.push_back('{64'd0, 1'b1, 1'b0, 27});
    send0(60'd0); wait_found0("w0"); consume0("w0");

    q0.push_back('{64'd1073741823, 1'b1, 1'b0, 27});
    send0(60'd576460751766552576); wait_found0("wmax"); consume0("wmax");

    q0.push_back('{64'd1073741823, 1'b0, 1'b1, 27});
    send0(60'd576460751766552577); wait_found0("wsat"); consume0("wsat");

    for (int i = 0; i < 3; i++) begin
      wr = {$urandom, $urandom} >> (i * 17);
      q0.push_back(model(64'(wr), 30, 27));
      send0(wr); wait_found0("rnd0"); consume0("rnd0");
    end

    // Back-to-back with in_valid and out_ready held high.
    wait_ready0("b2b");
    q0.push_back('{64'd4, 1'b1, 1'b0, 27});
    q0.push_back('{64'd4, 1'b0, 1'b0, 27});
    out_ready0 = 1'b1; W0 = 60'd10; in_valid0 = 1'b1;
    @(negedge clk);
    W0 = 60'd14;
    t = 0;
    while (!in_ready0 && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    in_valid0 = 1'b0;
    check_eq("b2b_interval", 64'(acc0 - acc0_prev), 64'd29);
    wait_found0("b2b");
    @(negedge clk);
    out_ready0 = 1'b0;
    check_eq("b2b_found_clr", 64'(found0), 64'd0);

    // Back-pressure: result must hold while new words are offered.
    q0.push_back('{64'd6, 1'b1, 1'b0, 27});
    send0(60'd21); wait_found0("bp");
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_found", 64'(found0), 64'd1);
      check_eq("bp_n", 64'(N0), 64'd6);
      check_eq("bp_exact", 64'(exact0), 64'd1);
      check_eq("bp_in_ready", 64'(in_ready0), 64'd0);
      W0 = {$urandom, $urandom}; in_valid0 = 1'b1;
      @(negedge clk);
    end
    in_valid0 = 1'b0;
    consume0("bp");
    repeat (5) @(negedge clk);
    check_eq("bp_single_found", 64'(found0), 64'd0);
    check_eq("bp_single_busy", 64'(busy0), 64'd0);

    // Reset in the middle of a search discards the partial result.
    send0(60'd1000000);
    repeat (9) @(negedge clk);
    check_eq("mid_busy", 64'(busy0), 64'd1);
    rst_n0 = 1'b0;
    #1;
    check_eq("mid_rst_found", 64'(found0), 64'd0);
    check_eq("mid_rst_n", 64'(N0), 64'd0);
    check_eq("mid_rst_exact", 64'(exact0), 64'd0);
    check_eq("mid_rst_sat", 64'(sat0), 64'd0);
    check_eq("mid_rst_busy", 64'(busy0), 64'd0);
    check_eq("mid_rst_in_ready", 64'(in_ready0), 64'd1);
    @(negedge clk);
    rst_n0 = 1'b1;
    @(negedge clk);
    q0.push_back('{64'd5, 1'b1, 1'b0, 27});
    send0(60'd15); wait_found0("post_rst"); consume0("post_rst");

    // N_BITS=8 sweeps; results are consumed as soon as they appear.
    q1.push_back('{64'd255, 1'b1, 1'b0, 1});
    q2.push_back('{64'd255, 1'b1, 1'b0, 8});
    send_s(16'd32640);
    q1.push_back('{64'd255, 1'b0, 1'b1, 1});
    q2.push_back('{64'd255, 1'b0, 1'b1, 8});
    send_s(16'd32641);
    q1.push_back('{64'd0, 1'b1, 1'b0, 1});
    q2.push_back('{64'd0, 1'b1, 1'b0, 8});
    send_s(16'd0);
    for (int i = 0; i < 20; i++) begin
      ws = 16'($urandom_range(0, 33000));
      q1.push_back(model(64'(ws), 8, 1));
      q2.push_back(model(64'(ws), 8, 8));
      send_s(ws);
    end
    repeat (15) @(negedge clk);

    check_eq("q0_drained", 64'(q0.size()), 64'd0);
    check_eq("q1_drained", 64'(q1.size()), 64'd0);
    check_eq("q2_drained", 64'(q2.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
